// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive port: bus addresses, FSM encoding,
// and status register bit positions.
package uart_pkg;
  localparam logic [31:0] RX_DATA_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] RX_STAT_ADDR = 32'hFFFF_FFF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int STAT_AVAIL = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_FERR  = 2;
  localparam int STAT_OVR   = 3;
endpackage

// File: rtl/rx_fifo.sv
// Byte FIFO for received characters; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate count.
module rx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic       WClk,
  input  logic       PresetFull,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]      mem_q [DEPTH];
  logic [ADDR_W:0] wp_q, wp_d, rp_q, rp_d;
  logic            do_push, do_pop;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[ADDR_W] != rp_q[ADDR_W]) &&
                   (wp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]);
  // A pop on a full FIFO does not open a slot for a same-cycle push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rp_q[ADDR_W-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (do_push) wp_d = wp_q + 1'b1;
    if (do_pop)  rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge WClk) begin
    if (do_push) mem_q[wp_q[ADDR_W-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver: 16x oversampling deframer feeding a byte
// FIFO, with data/status registers on the 32-bit CPU bus.
module uart_rx_port
  import uart_pkg::*;
#(
  parameter int          DIV       = 27,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] DATA_ADDR = RX_DATA_ADDR,
  parameter logic [31:0] STAT_ADDR = RX_STAT_ADDR
) (
  input  logic        WClk,
  input  logic        PresetFull,
  input  logic        rx,
  input  logic        re,
  input  logic [31:0] address,
  output logic [31:0] dataOut,
  output logic        rx_avail
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

  logic          sync1_q, rxs_q;
  logic [CW-1:0] div_q, div_d;
  logic          tick;
  rx_state_e     state_q, state_d;
  logic [3:0]    sc_q, sc_d;
  logic [2:0]    bi_q, bi_d;
  logic [7:0]    sh_q, sh_d;
  logic          ovr_q, ovr_d, ferr_q, ferr_d;
  logic          push, set_ovr, set_ferr;
  logic          sel_data, sel_stat;
  logic [7:0]    head;
  logic          full, empty;

  assign tick     = (div_q == CW'(DIV - 1));
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign sel_data = (address == DATA_ADDR);
  assign sel_stat = (address == STAT_ADDR);
  assign rx_avail = !empty;

  always_ff @(posedge WClk or posedge PresetFull) begin
    if (PresetFull) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      div_q   <= '0;
      state_q <= ST_IDLE;
      sc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      div_q   <= div_d;
      state_q <= state_d;
      sc_q    <= sc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bi_d     = bi_q;
    sh_d     = sh_q;
    push     = 1'b0;
    set_ovr  = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) begin
          state_d = ST_START;
          sc_d    = '0;
        end
      end
      ST_START: begin
        // Half a bit in, the line must still be low or the edge was a glitch.
        if (tick) begin
          if (sc_q == 4'd7) begin
            if (!rxs_q) begin
              state_d = ST_DATA;
              sc_d    = '0;
              bi_d    = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sc_q == 4'd15) begin
            sh_d = {rxs_q, sh_q[7:1]};
            sc_d = '0;
            if (bi_q == 3'd7) state_d = ST_STOP;
            else              bi_d    = bi_q + 3'd1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sc_q == 4'd15) begin
            state_d = ST_IDLE;
            if (!rxs_q)    set_ferr = 1'b1;
            else if (full) set_ovr  = 1'b1;
            else           push     = 1'b1;
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A status read clears the sticky flags unless a new event lands that cycle.
  always_comb begin
    ovr_d  = set_ovr  || (ovr_q  && !(re && sel_stat));
    ferr_d = set_ferr || (ferr_q && !(re && sel_stat));
  end

  always_comb begin
    dataOut = '0;
    if (sel_data) begin
      if (!empty) dataOut = {24'b0, head};
    end else if (sel_stat) begin
      dataOut[STAT_AVAIL] = !empty;
      dataOut[STAT_FULL]  = full;
      dataOut[STAT_FERR]  = ferr_q;
      dataOut[STAT_OVR]   = ovr_q;
    end
  end

  rx_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .WClk       (WClk),
    .PresetFull (PresetFull),
    .push       (push),
    .pop        (re && sel_data),
    .wdata      (sh_q),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );
endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: directed 8N1 frames plus random bytes, checked against
// a queue-based model of the receive FIFO and sticky status flags.
module tb_uart_rx_port;
  localparam int          BT = 64;
  localparam logic [31:0] DA = 32'hFFFF_FFFC;
  localparam logic [31:0] SA = 32'hFFFF_FFF8;

  logic        WClk = 1'b0;
  logic        PresetFull = 1'b1;
  logic        rx = 1'b1;
  logic        re = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] dataOut;
  logic        rx_avail;

  int checks = 0, failures = 0, cyc = 0, lat = 0;
  byte unsigned q[$];
  bit m_ovr = 1'b0, m_ferr = 1'b0;

  uart_rx_port #(.DIV(4), .ADDR_W(4)) dut (
    .WClk       (WClk),
    .PresetFull (PresetFull),
    .rx         (rx),
    .re         (re),
    .address    (address),
    .dataOut    (dataOut),
    .rx_avail   (rx_avail)
  );

  always #5 WClk = ~WClk;
  always @(posedge WClk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge WClk); #1; end
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  function automatic void m_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok)          m_ferr = 1'b1;
    else if (q.size() == 16) m_ovr = 1'b1;
    else                   q.push_back(b);
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit upd);
    align();
    rx = 1'b0; step(BT);
    for (int i = 0; i < 8; i++) begin rx = b[i]; step(BT); end
    if (stop_ok) begin rx = 1'b1; step(BT); end
    else begin rx = 1'b0; step(48); rx = 1'b1; step(16); end
    if (upd) m_frame(b, stop_ok);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address = a; re = 1'b1;
    @(negedge WClk); d = dataOut;
    step(); re = 1'b0; address = '0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    address = a; re = 1'b0;
    @(negedge WClk); d = dataOut;
    step(); address = '0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] d, e;
    e = (q.size() != 0) ? {24'b0, q[0]} : 32'b0;
    bus_read(DA, d);
    chk(tag, d, e);
    if (q.size() != 0) void'(q.pop_front());
    chk({tag, "_avail"}, {31'b0, rx_avail}, {31'b0, q.size() != 0});
  endtask

  task automatic rd_stat(input string tag);
    logic [31:0] d, e;
    e = {28'b0, m_ovr, m_ferr, q.size() == 16, q.size() != 0};
    bus_read(SA, d);
    chk(tag, d, e);
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Pops on exactly the edge where the incoming frame's push lands.
  task automatic timed_pop(input logic [7:0] b, input string tag);
    logic [31:0] d, e;
    bit was_full;
    align();
    e = (q.size() != 0) ? {24'b0, q[0]} : 32'b0;
    fork
      send_frame(b, 1'b1, 1'b0);
      begin
        step(lat - 1);
        address = DA; re = 1'b1;
        @(negedge WClk); d = dataOut;
        step(); re = 1'b0; address = '0;
      end
    join
    chk(tag, d, e);
    was_full = (q.size() == 16);
    if (q.size() != 0) void'(q.pop_front());
    if (was_full) m_ovr = 1'b1;
    else          q.push_back(b);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int s, p;
    bit ok;

    // Reset state
    step(3);
    chk("rst_avail", {31'b0, rx_avail}, 32'b0);
    peek(DA, d); chk("rst_data", d, 32'b0);
    peek(SA, d); chk("rst_stat", d, 32'b0);
    peek(32'h0, d); chk("rst_other", d, 32'b0);
    align(); PresetFull = 1'b0; step(8);

    // Single byte, measuring start-to-push latency on the way
    align(); s = cyc; p = -1;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        for (int k = 0; k < 1000 && p < 0; k++) begin
          @(negedge WClk);
          if (rx_avail) p = cyc;
        end
      end
    join
    lat = p - s;
    chk("t1_latency", {31'b0, (p >= 0) && lat >= 600 && lat <= 620}, 32'b1);
    peek(DA, d); chk("t1_peek", d, 32'h0000_00A5);
    rd_data("t1_pop");

    // Glitch rejection
    align(); rx = 1'b0; step(20); rx = 1'b1; step(200);
    chk("t2_avail", {31'b0, rx_avail}, 32'b0);
    rd_stat("t2_stat");

    // Framing error then clear
    send_frame(8'h3C, 1'b0, 1'b1);
    rd_stat("t3_ferr");
    rd_stat("t3_clr");

    // Overflow
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b1);
    rd_stat("t4_stat");
    for (int i = 0; i < 16; i++) rd_data("t4_data");
    rd_stat("t4_after");

    // Random bytes with occasional bad stop bits, interleaved reads
    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send_frame(b, ok, 1'b1);
      case ($urandom_range(0, 2))
        0: rd_data("rnd_data");
        1: rd_stat("rnd_stat");
        default: ;
      endcase
    end
    while (q.size() != 0) rd_data("rnd_drain");
    rd_stat("rnd_stat_end");

    // Pop coinciding with a push into a full FIFO
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    rd_stat("t5_full");
    timed_pop(8'($urandom), "t5_full_pop");
    rd_stat("t5_ovr");
    for (int i = 0; i < 15; i++) rd_data("t5_drain");

    // Pop coinciding with a push into a partly filled FIFO
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    timed_pop(8'($urandom), "t5b_pop");
    rd_stat("t5b_stat");
    for (int i = 0; i < 3; i++) rd_data("t5b_drain");

    // Reset in the middle of 0x55, with a stored byte pending
    send_frame(8'h42, 1'b1, 1'b1);
    align();
    rx = 1'b0; step(BT);
    rx = 1'b1; step(BT);
    rx = 1'b0; step(BT);
    rx = 1'b1; step(BT);
    rx = 1'b0; step(30);
    PresetFull = 1'b1;
    q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
    step(2);
    chk("t6_rst_avail", {31'b0, rx_avail}, 32'b0);
    peek(DA, d); chk("t6_rst_data", d, 32'b0);
    peek(SA, d); chk("t6_rst_stat", d, 32'b0);
    peek(32'h1234_5678, d); chk("t6_rst_other", d, 32'b0);
    align(); PresetFull = 1'b0;
    step(10); rx = 1'b1; step(100);
    send_frame(8'h81, 1'b1, 1'b1);
    rd_data("t6_data");
    rd_stat("t6_stat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
